// File: rtl/synch_updown_count_if.sv
// synch_updown_count_if: control/status bundle for the up/down counter.
// master drives ena/clr/load/load_val/up_dn; slave returns counter/tc/ovf.
interface synch_updown_count_if #(
    parameter int DWIDTH = 8
);
    logic              ena;
    logic              clr;
    logic              load;
    logic [DWIDTH-1:0] load_val;
    logic              up_dn;
    logic [DWIDTH-1:0] counter;
    logic              tc;
    logic              ovf;

    modport master (
        output ena,
        output clr,
        output load,
        output load_val,
        output up_dn,
        input  counter,
        input  tc,
        input  ovf
    );

    modport slave (
        input  ena,
        input  clr,
        input  load,
        input  load_val,
        input  up_dn,
        output counter,
        output tc,
        output ovf
    );
endinterface

// File: rtl/synch_updown_count.sv
// synch_updown_count: parametrised up/down counter, wrap or saturate.
// Ports: clk, rst (async, active high), bus (slave: ena, clr, load,
//   load_val, up_dn in; counter, tc, ovf out).
// Optional macro PRESCALE_EN: ena only steps every PRESCALE-th qualified edge.
module synch_updown_count #(
    parameter int DWIDTH   = 8,
    parameter int MAX_VAL  = 2**DWIDTH-1,
    parameter bit SAT_MODE = 1'b0,
    parameter int PRESCALE = 4
) (
    input logic                 clk,
    input logic                 rst,
    synch_updown_count_if.slave bus
);
    localparam logic [DWIDTH-1:0] MAXV = DWIDTH'(MAX_VAL);
    localparam logic [DWIDTH-1:0] ONE  = DWIDTH'(1);

    if (DWIDTH < 2) begin : g_bad_width
        $error("synch_updown_count: DWIDTH must be >= 2");
    end
    if (MAX_VAL < 1) begin : g_bad_max
        $error("synch_updown_count: MAX_VAL must be >= 1");
    end
    if (PRESCALE < 2) begin : g_bad_pre
        $error("synch_updown_count: PRESCALE must be >= 2");
    end

    logic [DWIDTH-1:0] cnt_q;
    logic [DWIDTH-1:0] cnt_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              at_max;
    logic              at_zero;
    logic              step;

    assign at_max  = (cnt_q == MAXV);
    assign at_zero = (cnt_q == '0);

`ifdef PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          req;

    // Only an unblocked ena advances the prescaler; clr/load restart it.
    assign req  = bus.ena & ~bus.clr & ~bus.load;
    assign step = req & (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (bus.clr | bus.load) begin
            pre_d = '0;
        end else if (req) begin
            pre_d = step ? '0 : pre_q + PRE_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign step = bus.ena & ~bus.clr & ~bus.load;
`endif

    // Next count: clr > load > step > hold. Limits never overshoot,
    // so no out-of-range value is ever registered.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (bus.load) begin
            if (bus.load_val > MAXV) begin
                cnt_d = MAXV;
            end else begin
                cnt_d = bus.load_val;
            end
        end else if (step) begin
            if (bus.up_dn) begin
                if (at_max) begin
                    cnt_d = SAT_MODE ? MAXV : '0;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    cnt_d = SAT_MODE ? '0 : MAXV;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.counter = cnt_q;
    assign bus.ovf     = ovf_q;
    // Terminal count follows up_dn combinationally, independent of ena.
    assign bus.tc      = bus.up_dn ? at_max : at_zero;
endmodule

// File: tb/tb_synch_updown_count.sv
// tb_synch_updown_count: scoreboard bench, wrap and saturate instances
// (DWIDTH=4, MAX_VAL=9) plus a DWIDTH=8 instance when PRESCALE_EN is set.
module tb_synch_updown_count;
    localparam int DW = 4;
    localparam int MV = 9;
    localparam int PS = 4;
`ifdef PRESCALE_EN
    localparam int ND = 3;
`else
    localparam int ND = 2;
`endif

    typedef struct {
        int c;
        bit o;
        bit t;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       clr;
    logic       load;
    logic       up_dn;
    logic [7:0] load_val;

    logic [7:0] act_c[3];
    logic       act_o[3];
    logic       act_t[3];

    int  mc[3];
    bit  mo[3];
    int  mp[3];
    int  mmax[3]  = '{9, 9, 255};
    int  mmask[3] = '{15, 15, 255};
    bit  msat[3]  = '{1'b0, 1'b1, 1'b0};

    sb_t sb[$];
    int  nchk = 0;
    int  nerr = 0;

    always #5 clk = ~clk;

    synch_updown_count_if #(.DWIDTH(DW)) bw ();
    synch_updown_count_if #(.DWIDTH(DW)) bs ();

    synch_updown_count #(
        .DWIDTH(DW), .MAX_VAL(MV), .SAT_MODE(1'b0), .PRESCALE(PS)
    ) dut_w (.clk(clk), .rst(rst), .bus(bw.slave));

    synch_updown_count #(
        .DWIDTH(DW), .MAX_VAL(MV), .SAT_MODE(1'b1), .PRESCALE(PS)
    ) dut_s (.clk(clk), .rst(rst), .bus(bs.slave));

    assign bw.ena      = ena;
    assign bw.clr      = clr;
    assign bw.load     = load;
    assign bw.up_dn    = up_dn;
    assign bw.load_val = load_val[3:0];
    assign bs.ena      = ena;
    assign bs.clr      = clr;
    assign bs.load     = load;
    assign bs.up_dn    = up_dn;
    assign bs.load_val = load_val[3:0];

    assign act_c[0] = {4'b0, bw.counter};
    assign act_o[0] = bw.ovf;
    assign act_t[0] = bw.tc;
    assign act_c[1] = {4'b0, bs.counter};
    assign act_o[1] = bs.ovf;
    assign act_t[1] = bs.tc;

`ifdef PRESCALE_EN
    synch_updown_count_if #(.DWIDTH(8)) bp ();

    synch_updown_count #(
        .DWIDTH(8), .MAX_VAL(255), .SAT_MODE(1'b0), .PRESCALE(PS)
    ) dut_p (.clk(clk), .rst(rst), .bus(bp.slave));

    assign bp.ena      = ena;
    assign bp.clr      = clr;
    assign bp.load     = load;
    assign bp.up_dn    = up_dn;
    assign bp.load_val = load_val;
    assign act_c[2]    = bp.counter;
    assign act_o[2]    = bp.ovf;
    assign act_t[2]    = bp.tc;
`else
    assign act_c[2] = 8'd0;
    assign act_o[2] = 1'b0;
    assign act_t[2] = 1'b0;
`endif

    function automatic void mreset();
        for (int d = 0; d < 3; d++) begin
            mc[d] = 0;
            mo[d] = 1'b0;
            mp[d] = 0;
        end
    endfunction

    function automatic void mstep(input int d, input bit r, input bit e,
                                  input bit c, input bit l, input bit u,
                                  input int lv);
        int mx;
        int v;
        bit tick;
        mx = mmax[d];
        v  = lv & mmask[d];
        mo[d] = 1'b0;
        if (r) begin
            mc[d] = 0;
            mp[d] = 0;
        end else if (c) begin
            mc[d] = 0;
            mp[d] = 0;
        end else if (l) begin
            mc[d] = (v > mx) ? mx : v;
            mp[d] = 0;
        end else if (e) begin
            tick = 1'b1;
`ifdef PRESCALE_EN
            if (mp[d] == PS - 1) begin
                mp[d] = 0;
            end else begin
                mp[d] = mp[d] + 1;
                tick = 1'b0;
            end
`endif
            if (tick) begin
                if (u) begin
                    if (mc[d] == mx) begin
                        mo[d] = 1'b1;
                        mc[d] = msat[d] ? mx : 0;
                    end else begin
                        mc[d] = mc[d] + 1;
                    end
                end else begin
                    if (mc[d] == 0) begin
                        mo[d] = 1'b1;
                        mc[d] = msat[d] ? 0 : mx;
                    end else begin
                        mc[d] = mc[d] - 1;
                    end
                end
            end
        end
    endfunction

    // Drive one cycle of stimulus and queue the model's post-edge view.
    task automatic drive(input bit r, input bit e, input bit c,
                         input bit l, input bit u, input int lv);
        sb_t s;
        rst      = r;
        ena      = e;
        clr      = c;
        load     = l;
        up_dn    = u;
        load_val = 8'(lv);
        for (int d = 0; d < ND; d++) begin
            mstep(d, r, e, c, l, u, lv);
            s.c = mc[d];
            s.o = mo[d];
            s.t = u ? (mc[d] == mmax[d]) : (mc[d] == 0);
            sb.push_back(s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sb_t s;
        rst = 1'b1; ena = 1'b0; clr = 1'b0; load = 1'b0;
        up_dn = 1'b1; load_val = 8'd0;
        mreset();
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            nchk++;
            if (act_c[d] !== 8'd0 || act_o[d] !== 1'b0) begin
                nerr++;
                $display("FAIL reset_state dut%0d: cnt=%0d ovf=%b want 0 0",
                         d, act_c[d], act_o[d]);
            end
        end
        for (int i = 0; i < 5 + 3; i++) begin
            if (i < 5) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
            else drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
            for (int d = 0; d < ND; d++) begin
                s = sb.pop_front();
                nchk++;
                if (act_c[d] !== 8'(s.c) || act_o[d] !== s.o) begin
                    nerr++;
                    $display("FAIL reset_seq dut%0d i%0d: cnt=%0d ovf=%b want %0d %b",
                             d, i, act_c[d], act_o[d], s.c, s.o);
                end
            end
            if (i == 4) begin
                #2;
                rst = 1'b1;
                #1;
                mreset();
                for (int d = 0; d < ND; d++) begin
                    nchk++;
                    if (act_c[d] !== 8'd0 || act_o[d] !== 1'b0) begin
                        nerr++;
                        $display("FAIL reset_async dut%0d: cnt=%0d ovf=%b want 0 0",
                                 d, act_c[d], act_o[d]);
                    end
                end
            end
        end
        // Reset landing on a pending ovf pulse must kill it.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 2 * ND; k++) void'(sb.pop_front());
        nchk++;
        if (act_o[0] !== (ND == 2 ? 1'b1 : 1'b0)) begin
            nerr++;
            $display("FAIL reset_ovf_setup: ovf=%b", act_o[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        mreset();
        for (int d = 0; d < ND; d++) begin
            nchk++;
            if (act_c[d] !== 8'd0 || act_o[d] !== 1'b0) begin
                nerr++;
                $display("FAIL reset_kill_ovf dut%0d: cnt=%0d ovf=%b want 0 0",
                         d, act_c[d], act_o[d]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < ND; k++) void'(sb.pop_front());
    endtask

    task automatic test_wrap_up();
        sb_t s;
        int  ew[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        for (int k = 0; k < ND; k++) void'(sb.pop_front());
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
            for (int d = 0; d < ND; d++) begin
                s = sb.pop_front();
                nchk++;
                if (act_c[d] !== 8'(s.c) || act_o[d] !== s.o ||
                    act_t[d] !== s.t) begin
                    nerr++;
                    $display("FAIL wrap_up dut%0d i%0d: cnt=%0d ovf=%b tc=%b want %0d %b %b",
                             d, i, act_c[d], act_o[d], act_t[d], s.c, s.o, s.t);
                end
            end
`ifndef PRESCALE_EN
            nchk++;
            if (act_c[0] !== 8'(ew[i]) || act_o[0] !== (i == 9) ||
                act_t[0] !== (ew[i] == 9)) begin
                nerr++;
                $display("FAIL wrap_table i%0d: cnt=%0d ovf=%b tc=%b want %0d",
                         i, act_c[0], act_o[0], act_t[0], ew[i]);
            end
`endif
        end
    endtask

    task automatic test_sat_down();
        sb_t s;
        int  es[4] = '{1, 0, 0, 0};
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        for (int k = 0; k < ND; k++) void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
            for (int d = 0; d < ND; d++) begin
                s = sb.pop_front();
                nchk++;
                if (act_c[d] !== 8'(s.c) || act_o[d] !== s.o ||
                    act_t[d] !== s.t) begin
                    nerr++;
                    $display("FAIL sat_down dut%0d i%0d: cnt=%0d ovf=%b tc=%b want %0d %b %b",
                             d, i, act_c[d], act_o[d], act_t[d], s.c, s.o, s.t);
                end
            end
`ifndef PRESCALE_EN
            nchk++;
            if (act_c[1] !== 8'(es[i]) || act_o[1] !== (i >= 2) ||
                act_t[1] !== (es[i] == 0)) begin
                nerr++;
                $display("FAIL sat_table i%0d: cnt=%0d ovf=%b tc=%b want %0d",
                         i, act_c[1], act_o[1], act_t[1], es[i]);
            end
`endif
        end
    endtask

    task automatic test_priority();
        sb_t s;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 13);
            else if (i == 1) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3);
            else drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
            for (int d = 0; d < ND; d++) begin
                s = sb.pop_front();
                nchk++;
                if (act_c[d] !== 8'(s.c) || act_o[d] !== s.o ||
                    act_t[d] !== s.t) begin
                    nerr++;
                    $display("FAIL priority dut%0d i%0d: cnt=%0d ovf=%b tc=%b want %0d %b %b",
                             d, i, act_c[d], act_o[d], act_t[d], s.c, s.o, s.t);
                end
            end
            if (i == 0) begin
                nchk++;
                if (act_c[0] !== 8'd9 || act_c[1] !== 8'd9) begin
                    nerr++;
                    $display("FAIL clamp: cnt=%0d/%0d want 9",
                             act_c[0], act_c[1]);
                end
            end
        end
    endtask

    task automatic test_direction();
        sb_t s;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        for (int k = 0; k < ND; k++) void'(sb.pop_front());
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, (i < 4), 0);
            for (int d = 0; d < ND; d++) begin
                s = sb.pop_front();
                nchk++;
                if (act_c[d] !== 8'(s.c) || act_o[d] !== s.o ||
                    act_t[d] !== s.t) begin
                    nerr++;
                    $display("FAIL direction dut%0d i%0d: cnt=%0d ovf=%b tc=%b want %0d %b %b",
                             d, i, act_c[d], act_o[d], act_t[d], s.c, s.o, s.t);
                end
            end
        end
`ifndef PRESCALE_EN
        nchk++;
        if (act_c[0] !== 8'd2) begin
            nerr++;
            $display("FAIL dir_end: cnt=%0d want 2", act_c[0]);
        end
`endif
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        for (int k = 0; k < ND; k++) void'(sb.pop_front());
        ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            up_dn = (i == 0) ? 1'b0 : 1'b1;
            #1;
            for (int d = 0; d < ND; d++) begin
                nchk++;
                if (act_t[d] !== ~up_dn) begin
                    nerr++;
                    $display("FAIL tc_toggle dut%0d up=%b: tc=%b want %b",
                             d, up_dn, act_t[d], ~up_dn);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        sb_t s;
        for (int i = 0; i < 200; i++) begin
            drive(1'b0, ($urandom % 4) != 0, ($urandom % 16) == 0,
                  ($urandom % 8) == 0, ($urandom % 3) != 0,
                  int'($urandom_range(0, 15)));
            for (int d = 0; d < ND; d++) begin
                s = sb.pop_front();
                nchk++;
                if (act_c[d] !== 8'(s.c) || act_o[d] !== s.o ||
                    act_t[d] !== s.t) begin
                    nerr++;
                    $display("FAIL random dut%0d i%0d: cnt=%0d ovf=%b tc=%b want %0d %b %b",
                             d, i, act_c[d], act_o[d], act_t[d], s.c, s.o, s.t);
                end
            end
        end
    endtask

`ifdef PRESCALE_EN
    task automatic test_prescale();
        sb_t s;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        for (int k = 0; k < ND; k++) void'(sb.pop_front());
        for (int i = 0; i < 19; i++) begin
            drive(1'b0, (i != 11), (i == 11), 1'b0, 1'b1, 0);
            for (int d = 0; d < ND; d++) begin
                s = sb.pop_front();
                nchk++;
                if (act_c[d] !== 8'(s.c) || act_o[d] !== s.o ||
                    act_t[d] !== s.t) begin
                    nerr++;
                    $display("FAIL prescale dut%0d i%0d: cnt=%0d ovf=%b want %0d %b",
                             d, i, act_c[d], act_o[d], s.c, s.o);
                end
            end
            if (i == 7 || i == 10 || i == 14 || i == 15) begin
                nchk++;
                if (act_c[2] !== ((i == 14) ? 8'd0 : (i == 15) ? 8'd1 : 8'd2)) begin
                    nerr++;
                    $display("FAIL prescale_pt i%0d: cnt=%0d", i, act_c[2]);
                end
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_priority();
        test_direction();
`ifdef PRESCALE_EN
        test_prescale();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/synch_updown_count.md
Name: synch_updown_count

Overview:
Parametrised synchronous up/down binary counter. It generalises the fixed 4-bit enable-only counter with the following features:
- configurable width and modulus
- direction control
- synchronous clear and parallel load
- wrap or saturate mode
- terminal-count and overflow flags

It sits in the timing/control datapath as the general-purpose event counter, timer base and address generator.

Parameters:
- DWIDTH, 8, counter width in bits (>=2).
- MAX_VAL, 2**DWIDTH-1, highest count value (modulus = MAX_VAL+1); must satisfy 1 <= MAX_VAL <= 2**DWIDTH-1.
- SAT_MODE, 0, 0 = wrap at limits, 1 = saturate at limits.
- PRESCALE, 4, ena qualifying divisor; used only when PRESCALE_EN is defined (>=2).

Ports:
- clk  input  1  Clock; all state updates on the rising edge.
- rst  input  1  Asynchronous active-high reset.
- ena  input  1  Count enable; sampled on the rising edge.
- clr  input  1  Synchronous clear to 0.
- load  input  1  Synchronous parallel load.
- load_val  input  DWIDTH  Value loaded when load=1.
- up_dn  input  1  Direction: 1 = up, 0 = down.
- counter  output  DWIDTH  Registered count value.
- tc  output  1  Terminal count (combinational from counter and up_dn).
- ovf  output  1  Registered one-cycle pulse on a limit crossing or attempt.

Behaviour:
- Reset: rst=1 asynchronously forces counter=0, ovf=0 and the prescaler state=0, independent of clk. Release is synchronous to the next clk edge; the first update happens on the first rising edge with rst=0.
- Per-edge priority: rst > clr > load > count > hold.
- clr=1: counter<=0 and ovf<=0. This happens regardless of ena, load or up_dn.
- load=1 (clr=0): counter<=load_val if load_val<=MAX_VAL, otherwise counter<=MAX_VAL (clamp). ovf<=0. ena is ignored.
- Count condition: ena=1 (qualified by the prescaler if enabled) with clr=0 and load=0.
  - Up, counter<MAX_VAL: counter+1, ovf<=0.
  - Up, counter==MAX_VAL: SAT_MODE=0 gives counter<=0; SAT_MODE=1 holds MAX_VAL. In both modes ovf<=1.
  - Down, counter>0: counter-1, ovf<=0.
  - Down, counter==0: SAT_MODE=0 gives counter<=MAX_VAL; SAT_MODE=1 holds 0. In both modes ovf<=1.
- Hold: when no clr, load or count applies, counter holds and ovf<=0.
- ovf width: ovf is high for exactly one cycle per limit event. With ena held high in saturate mode at a limit, ovf stays high on every such edge.
- Latency:
  - counter changes on the same edge that samples the control inputs.
  - ovf is asserted in the cycle after the edge, aligned with the wrapped/held counter value.
- tc = (up_dn & counter==MAX_VAL) | (~up_dn & counter==0). tc does not depend on ena. It changes immediately when up_dn toggles.
- Direction change mid-count takes effect on the next counting edge. There is no pipeline.
- Arithmetic: unsigned modulo MAX_VAL+1. No intermediate value outside 0..MAX_VAL is ever registered. Comparisons are DWIDTH bits wide.
- Non-power-of-two MAX_VAL: counter never exceeds MAX_VAL. A load of an out-of-range value is clamped.
- Reset mid-operation: rst asserted between edges clears counter immediately and kills any pending ovf.

Optional Feature:
Macro PRESCALE_EN.
- Defined: an internal prescaler counter (width clog2(PRESCALE)) increments on each edge where ena=1 with clr=0 and load=0. The main counter steps only on the edge where the prescaler is at PRESCALE-1; the prescaler then returns to 0.
  - clr and load also reset the prescaler to 0.
  - rst resets it asynchronously.
  - ena=0 freezes the prescaler.
- Not defined: no prescaler logic exists and ena qualifies every edge directly. The PRESCALE parameter is ignored.

Test Plan:
All scenarios use DWIDTH=4 and MAX_VAL=9 unless stated.
- Reset: assert rst between edges with counter=5 -> counter=0 and ovf=0 before the next edge. Hold rst for 3 edges with ena=1 -> counter stays 0.
- Wrap up (SAT_MODE=0): up_dn=1, ena=1 for 12 edges -> counter sequence 1..9,0,1,2. ovf=1 only in the cycle where counter=0. tc=1 while counter=9.
- Saturate down (SAT_MODE=1): load 2, then up_dn=0, ena=1 for 4 edges -> counter 1,0,0,0. ovf=1 on the third and fourth cycles. tc=1 while counter=0.
- Priority/clamp:
  - load=1 with load_val=13 and ena=1 -> counter=9.
  - Next edge with clr=1, load=1, load_val=3 -> counter=0.
  - ena=0 for 5 edges -> counter holds 0.
- Direction change: count up to 4, toggle up_dn=0 with ena=1 -> 3,2. Toggling up_dn while counter=0 flips tc combinationally without an edge.
- PRESCALE_EN defined, PRESCALE=4, DWIDTH=8 and MAX_VAL=255:
  - 8 edges with ena=1 -> counter=2.
  - 3 more edges of ena=1, then clr -> counter=0 and the prescaler restarts, so the next step needs 4 more ena edges.
